// File: rtl/multi_lane_staged_mac.sv
// Multi-lane signed MAC with saturation, optional cross-lane reduction and a 2-entry result buffer.
// Ports: ACLK/ARESET, SD_AXIS_* operand stream in (bias beat then MAC beats), MO_AXIS_* result out.
module multi_lane_staged_mac #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_LANES      = 4,
  parameter int C_ACC_WIDTH  = 32
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  output logic                               SD_AXIS_TREADY,
  input  logic [C_LANES*2*C_DATA_WIDTH-1:0]  SD_AXIS_TDATA,
  input  logic                               SD_AXIS_TVALID,
  input  logic                               SD_AXIS_TLAST,
  input  logic                               SD_AXIS_TUSER,
  input  logic [7:0]                         SD_AXIS_TID,
  output logic                               MO_AXIS_TVALID,
  output logic [C_LANES*C_ACC_WIDTH-1:0]     MO_AXIS_TDATA,
  output logic                               MO_AXIS_TLAST,
  output logic [C_LANES-1:0]                 MO_AXIS_TUSER,
  output logic [7:0]                         MO_AXIS_TID,
  input  logic                               MO_AXIS_TREADY
);

  localparam int W  = C_DATA_WIDTH;
  localparam int L  = C_LANES;
  localparam int A  = C_ACC_WIDTH;
  localparam int PW = 2 * W;
  localparam int RW = A + $clog2(L);

  localparam logic [A-1:0] ACC_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic [A-1:0] ACC_MIN = {1'b1, {(A-1){1'b0}}};
  localparam logic signed [RW-1:0] RED_MAX =
    {{(RW-A+1){1'b0}}, {(A-1){1'b1}}};
  localparam logic signed [RW-1:0] RED_MIN =
    {{(RW-A+1){1'b1}}, {(A-1){1'b0}}};

  typedef enum logic {BIAS, MAC} state_t;

  state_t              state_q, state_d;
  logic [L-1:0][A-1:0] acc_q, acc_d;
  logic [L-1:0]        ovf_q, ovf_d;
  logic                mode_q, mode_d;
  logic [7:0]          tag_q, tag_d;

  logic [1:0][L*A-1:0] fd_q, fd_d;
  logic [1:0][L-1:0]   fu_q, fu_d;
  logic [1:0][7:0]     ft_q, ft_d;
  logic [1:0]          cnt_q, cnt_d;

  logic [L-1:0][A-1:0] mac_val, bias_val;
  logic [L-1:0]        mac_sat;
  logic                accept, push, pop;

  logic signed [RW-1:0] red_sum;
  logic                 red_sat;
  logic [A-1:0]         red_val;
  logic [L*A-1:0]       new_d;
  logic [L-1:0]         new_u;

  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [PW-1:0]        slot;
    logic signed [PW-1:0] prod;
    logic [A:0]           sum;
    assign slot = SD_AXIS_TDATA[k*PW +: PW];
    assign prod = $signed(slot[PW-1:W]) * $signed(slot[W-1:0]);
    // One guard bit: sign and guard disagree exactly on overflow.
    assign sum = {acc_q[k][A-1], acc_q[k]}
               + {{(A+1-PW){prod[PW-1]}}, prod};
    assign mac_sat[k] = sum[A] ^ sum[A-1];
    assign mac_val[k] = mac_sat[k] ? (sum[A] ? ACC_MIN : ACC_MAX)
                                   : sum[A-1:0];
    assign bias_val[k] = {{(A-PW){slot[PW-1]}}, slot};
  end

  assign SD_AXIS_TREADY = !ARESET && (cnt_q != 2'd2);
  assign accept = SD_AXIS_TVALID && SD_AXIS_TREADY;
  assign pop    = (cnt_q != 2'd0) && MO_AXIS_TREADY;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    push    = 1'b0;
    if (accept) begin
      unique case (state_q)
        BIAS: begin
          acc_d  = bias_val;
          ovf_d  = '0;
          mode_d = SD_AXIS_TUSER;
          tag_d  = SD_AXIS_TID;
          if (SD_AXIS_TLAST) push = 1'b1;
          else state_d = MAC;
        end
        MAC: begin
          acc_d = mac_val;
          ovf_d = ovf_q | mac_sat;
          if (SD_AXIS_TLAST) begin
            push    = 1'b1;
            state_d = BIAS;
          end
        end
        default: state_d = BIAS;
      endcase
    end
  end

  // Reduction is taken over the freshly updated lane values.
  always_comb begin
    red_sum = '0;
    for (int k = 0; k < L; k++) begin
      red_sum = red_sum + RW'($signed(acc_d[k]));
    end
    red_sat = (red_sum > RED_MAX) || (red_sum < RED_MIN);
    if (!red_sat) red_val = red_sum[A-1:0];
    else if (red_sum[RW-1]) red_val = ACC_MIN;
    else red_val = ACC_MAX;
    new_d = acc_d;
    new_u = ovf_d;
    if (mode_d) begin
      new_d          = '0;
      new_d[A-1:0]   = red_val;
      new_u          = '0;
      new_u[0]       = (|ovf_d) || red_sat;
    end
  end

  // Slot 0 is always the head; push never happens at count 2.
  always_comb begin
    fd_d  = fd_q;
    fu_d  = fu_q;
    ft_d  = ft_q;
    cnt_d = cnt_q;
    if (push && pop) begin
      if (cnt_q == 2'd1) begin
        fd_d[0] = new_d;
        fu_d[0] = new_u;
        ft_d[0] = tag_d;
      end else begin
        fd_d[0] = fd_q[1];
        fu_d[0] = fu_q[1];
        ft_d[0] = ft_q[1];
        fd_d[1] = new_d;
        fu_d[1] = new_u;
        ft_d[1] = tag_d;
      end
    end else if (pop) begin
      fd_d[0] = fd_q[1];
      fu_d[0] = fu_q[1];
      ft_d[0] = ft_q[1];
      cnt_d   = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        fd_d[0] = new_d;
        fu_d[0] = new_u;
        ft_d[0] = tag_d;
      end else begin
        fd_d[1] = new_d;
        fu_d[1] = new_u;
        ft_d[1] = tag_d;
      end
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= BIAS;
      acc_q   <= '0;
      ovf_q   <= '0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      fd_q    <= '0;
      fu_q    <= '0;
      ft_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      fd_q    <= fd_d;
      fu_q    <= fu_d;
      ft_q    <= ft_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MO_AXIS_TVALID = (cnt_q != 2'd0);
  assign MO_AXIS_TLAST  = MO_AXIS_TVALID;
  assign MO_AXIS_TDATA  = fd_q[0];
  assign MO_AXIS_TUSER  = fu_q[0];
  assign MO_AXIS_TID    = ft_q[0];

endmodule

// File: tb/tb_multi_lane_staged_mac.sv
// Bench for multi_lane_staged_mac: 32-bit and 16-bit accumulator instances on one shared stream.
// Results are checked against a plain-arithmetic packet model.
module tb_multi_lane_staged_mac;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid, s_tlast, s_tuser;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tid;
  logic         m_tready;
  logic         a_sready, b_sready;
  logic         a_tvalid, b_tvalid, a_tlast, b_tlast;
  logic [127:0] a_tdata;
  logic [63:0]  b_tdata;
  logic [3:0]   a_tuser, b_tuser;
  logic [7:0]   a_tid, b_tid;

  always #5 clk = ~clk;

  multi_lane_staged_mac #(.C_DATA_WIDTH(8), .C_LANES(4), .C_ACC_WIDTH(32)) dut32 (
    .ACLK(clk), .ARESET(rst), .SD_AXIS_TREADY(a_sready),
    .SD_AXIS_TDATA(s_tdata), .SD_AXIS_TVALID(s_tvalid),
    .SD_AXIS_TLAST(s_tlast), .SD_AXIS_TUSER(s_tuser), .SD_AXIS_TID(s_tid),
    .MO_AXIS_TVALID(a_tvalid), .MO_AXIS_TDATA(a_tdata),
    .MO_AXIS_TLAST(a_tlast), .MO_AXIS_TUSER(a_tuser), .MO_AXIS_TID(a_tid),
    .MO_AXIS_TREADY(m_tready));

  multi_lane_staged_mac #(.C_DATA_WIDTH(8), .C_LANES(4), .C_ACC_WIDTH(16)) dut16 (
    .ACLK(clk), .ARESET(rst), .SD_AXIS_TREADY(b_sready),
    .SD_AXIS_TDATA(s_tdata), .SD_AXIS_TVALID(s_tvalid),
    .SD_AXIS_TLAST(s_tlast), .SD_AXIS_TUSER(s_tuser), .SD_AXIS_TID(s_tid),
    .MO_AXIS_TVALID(b_tvalid), .MO_AXIS_TDATA(b_tdata),
    .MO_AXIS_TLAST(b_tlast), .MO_AXIS_TUSER(b_tuser), .MO_AXIS_TID(b_tid),
    .MO_AXIS_TREADY(m_tready));

  int checks = 0;
  int failures = 0;
  bit use_gaps = 0;

  longint     pk_bias[4];
  int         pk_in[8][4];
  int         pk_wt[8][4];
  int         pk_n;
  bit         pk_mode;
  logic [7:0] pk_tid;

  logic [127:0] e32d;
  logic [63:0]  e16d;
  logic [3:0]   e32u, e16u;

  // Packet-level reference: saturating accumulate, then optional lane sum.
  function automatic void run_model(input int A,
                                    output logic [127:0] data,
                                    output logic [3:0] user);
    longint mx, mn, s;
    longint acc[4];
    longint v[4];
    logic [63:0] bits;
    bit [3:0] fl;
    bit rs;
    mx = (64'sd1 <<< (A - 1)) - 1;
    mn = -mx - 1;
    fl = '0;
    for (int k = 0; k < 4; k++) acc[k] = pk_bias[k];
    for (int b = 0; b < pk_n; b++)
      for (int k = 0; k < 4; k++) begin
        acc[k] = acc[k] + longint'(pk_in[b][k] * pk_wt[b][k]);
        if (acc[k] > mx) begin acc[k] = mx; fl[k] = 1; end
        else if (acc[k] < mn) begin acc[k] = mn; fl[k] = 1; end
      end
    if (pk_mode) begin
      s = acc[0] + acc[1] + acc[2] + acc[3];
      rs = 0;
      if (s > mx) begin s = mx; rs = 1; end
      else if (s < mn) begin s = mn; rs = 1; end
      v[0] = s; v[1] = 0; v[2] = 0; v[3] = 0;
      user = {3'b000, (|fl) | rs};
    end else begin
      for (int k = 0; k < 4; k++) v[k] = acc[k];
      user = fl;
    end
    data = '0;
    for (int k = 0; k < 4; k++) begin
      bits = v[k];
      for (int i = 0; i < A; i++) data[k*A + i] = bits[i];
    end
  endfunction

  function automatic void model_both();
    logic [127:0] t;
    run_model(32, e32d, e32u);
    run_model(16, t, e16u);
    e16d = t[63:0];
  endfunction

  task automatic drive_beat(input logic [63:0] d, input bit last,
                            input bit user, input logic [7:0] id);
    int n;
    if (use_gaps)
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_tdata = d; s_tlast = last; s_tuser = user; s_tid = id;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_sready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!a_sready) begin
      failures++;
      $display("FAIL beat_accept: tready=%0b after %0d cycles, need 1",
               a_sready, n);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_packet();
    logic [63:0] d;
    logic [15:0] bv;
    logic [7:0] iv, wv;
    for (int k = 0; k < 4; k++) begin
      bv = 16'(pk_bias[k]);
      d[k*16 +: 16] = bv;
    end
    drive_beat(d, pk_n == 0, pk_mode, pk_tid);
    for (int b = 0; b < pk_n; b++) begin
      for (int k = 0; k < 4; k++) begin
        iv = 8'(pk_in[b][k]);
        wv = 8'(pk_wt[b][k]);
        d[k*16 +: 16] = {iv, wv};
      end
      drive_beat(d, b == pk_n - 1, 1'($urandom), 8'($urandom));
    end
  endtask

  task automatic set_spec_packet(input bit mode);
    pk_bias[0] = 10; pk_bias[1] = -5; pk_bias[2] = 0; pk_bias[3] = 100;
    pk_n = 1;
    pk_in[0][0] = 3;    pk_wt[0][0] = 4;
    pk_in[0][1] = -2;   pk_wt[0][1] = 7;
    pk_in[0][2] = 5;    pk_wt[0][2] = -6;
    pk_in[0][3] = -128; pk_wt[0][3] = -128;
    pk_mode = mode;
    pk_tid = 8'h3A;
  endtask

  task automatic test_reset_state();
    checks++;
    if (a_tvalid !== 0 || a_sready !== 0 || a_tdata !== '0 ||
        a_tuser !== '0 || a_tid !== '0 || a_tlast !== 0) begin
      failures++;
      $display("FAIL reset_outputs: v=%0b rdy=%0b d=%h u=%h id=%h l=%0b, need all 0",
               a_tvalid, a_sready, a_tdata, a_tuser, a_tid, a_tlast);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (a_sready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %0b need 1", a_sready);
    end
  endtask

  task automatic test_per_lane();
    set_spec_packet(1'b0);
    send_packet();
    checks++;
    if (a_tvalid !== 1 || a_tlast !== 1 ||
        a_tdata !== {32'd16484, 32'hFFFFFFE2, 32'hFFFFFFED, 32'd22}) begin
      failures++;
      $display("FAIL per_lane_data: v=%0b l=%0b d=%h", a_tvalid, a_tlast, a_tdata);
    end
    checks++;
    if (a_tuser !== 4'b0000 || a_tid !== 8'h3A) begin
      failures++;
      $display("FAIL per_lane_side: u=%h id=%h need 0/3a", a_tuser, a_tid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reduction();
    set_spec_packet(1'b1);
    send_packet();
    checks++;
    if (a_tvalid !== 1 || a_tdata !== {96'd0, 32'd16457} || a_tuser !== 4'b0000) begin
      failures++;
      $display("FAIL reduction: v=%0b d=%h u=%h need lane0=16457 u=0",
               a_tvalid, a_tdata, a_tuser);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    pk_bias[0] = 32767; pk_bias[1] = -32768; pk_bias[2] = 0; pk_bias[3] = 0;
    pk_n = 2;
    pk_in[0][0] = 1;  pk_wt[0][0] = 1;  pk_in[1][0] = -1; pk_wt[1][0] = 1;
    pk_in[0][1] = -1; pk_wt[0][1] = 1;  pk_in[1][1] = 0;  pk_wt[1][1] = 0;
    for (int b = 0; b < 2; b++)
      for (int k = 2; k < 4; k++) begin pk_in[b][k] = 0; pk_wt[b][k] = 0; end
    pk_mode = 0;
    pk_tid = 8'h5C;
    model_both();
    send_packet();
    checks++;
    if (b_tvalid !== 1 || b_tdata !== {16'h0000, 16'h0000, 16'h8000, 16'h7FFE} ||
        b_tuser !== 4'b0011) begin
      failures++;
      $display("FAIL sat16: v=%0b d=%h u=%b need 00000000_8000_7ffe u=0011",
               b_tvalid, b_tdata, b_tuser);
    end
    checks++;
    if (a_tdata !== e32d || a_tuser !== e32u || a_tid !== 8'h5C) begin
      failures++;
      $display("FAIL sat32_nosat: d=%h u=%b need %h %b", a_tdata, a_tuser, e32d, e32u);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    for (int k = 0; k < 4; k++) pk_bias[k] = -7;
    pk_n = 0;
    pk_mode = 0;
    pk_tid = 8'h11;
    send_packet();
    checks++;
    if (a_tvalid !== 1 || a_tdata !== {4{32'hFFFFFFF9}} || a_tuser !== 4'b0 ||
        b_tdata !== {4{16'hFFF9}} || a_tid !== 8'h11) begin
      failures++;
      $display("FAIL single_beat: d32=%h d16=%h u=%b id=%h",
               a_tdata, b_tdata, a_tuser, a_tid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    use_gaps = 1;
    for (int p = 0; p < 24; p++) begin
      pk_n = $urandom_range(0, 6);
      pk_mode = 1'($urandom);
      pk_tid = 8'($urandom);
      for (int k = 0; k < 4; k++)
        pk_bias[k] = longint'($urandom_range(0, 65535)) - 32768;
      for (int b = 0; b < pk_n; b++)
        for (int k = 0; k < 4; k++) begin
          pk_in[b][k] = int'($urandom_range(0, 255)) - 128;
          pk_wt[b][k] = int'($urandom_range(0, 255)) - 128;
        end
      model_both();
      send_packet();
      checks++;
      if (a_tvalid !== 1 || a_tdata !== e32d || a_tuser !== e32u || a_tid !== pk_tid) begin
        failures++;
        $display("FAIL random32 pkt%0d: d=%h u=%b id=%h need %h %b %h",
                 p, a_tdata, a_tuser, a_tid, e32d, e32u, pk_tid);
      end
      checks++;
      if (b_tvalid !== 1 || b_tdata !== e16d || b_tuser !== e16u || b_tid !== pk_tid) begin
        failures++;
        $display("FAIL random16 pkt%0d: d=%h u=%b id=%h need %h %b %h",
                 p, b_tdata, b_tuser, b_tid, e16d, e16u, pk_tid);
      end
      @(posedge clk); #1;
    end
    use_gaps = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd[3];
    logic [7:0]  rt[3];
    int got;
    m_tready = 1'b0;
    pk_n = 0;
    pk_mode = 0;
    for (int i = 1; i <= 2; i++) begin
      for (int k = 0; k < 4; k++) pk_bias[k] = i;
      pk_tid = 8'(i);
      send_packet();
    end
    checks++;
    if (a_sready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: tready=%0b with 2 buffered, need 0", a_sready);
    end
    for (int k = 0; k < 4; k++) pk_bias[k] = 3;
    pk_tid = 8'd3;
    got = 0;
    fork
      send_packet();
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (a_tvalid !== 1 || a_tdata[31:0] !== 32'd1 || a_tid !== 8'd1) begin
          failures++;
          $display("FAIL stall_hold: v=%0b lane0=%0d id=%0d need 1/1/1",
                   a_tvalid, a_tdata[31:0], a_tid);
        end
        m_tready = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
          if (a_tvalid) begin
            rd[got] = a_tdata[31:0];
            rt[got] = a_tid;
            got++;
          end
          @(negedge clk);
        end
      end
    join
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results need 3", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (rd[i] !== 32'(i + 1) || rt[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL b2b_order%0d: lane0=%0d id=%0d need %0d", i, rd[i], rt[i], i + 1);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (a_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_dup: extra result lane0=%0d", a_tdata[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    pk_n = 0;
    pk_mode = 0;
    for (int k = 0; k < 4; k++) pk_bias[k] = 5;
    pk_tid = 8'h55;
    send_packet();
    drive_beat(64'h0010_0020_0030_0040, 1'b0, 1'b0, 8'h66);
    drive_beat(64'h0303_0303_0303_0303, 1'b0, 1'b0, 8'h00);
    drive_beat(64'h0202_0202_0202_0202, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    checks++;
    if (a_tvalid !== 0 || a_sready !== 0 || a_tdata !== '0) begin
      failures++;
      $display("FAIL reset_mid: v=%0b rdy=%0b d=%h need 0", a_tvalid, a_sready, a_tdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_tready = 1'b1;
    pk_bias[0] = 1; pk_bias[1] = 2; pk_bias[2] = 3; pk_bias[3] = -4;
    pk_n = 1;
    for (int k = 0; k < 4; k++) begin pk_in[0][k] = 2; pk_wt[0][k] = -3; end
    pk_tid = 8'h77;
    model_both();
    send_packet();
    checks++;
    if (a_tvalid !== 1 || a_tdata !== e32d || a_tid !== 8'h77 || a_tuser !== e32u) begin
      failures++;
      $display("FAIL post_reset: v=%0b d=%h id=%h need %h id 77",
               a_tvalid, a_tdata, a_tid, e32d);
    end
    @(posedge clk); #1;
    checks++;
    if (a_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_extra: stale result id=%h", a_tid);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tvalid = 0; s_tlast = 0; s_tuser = 0; s_tid = '0; s_tdata = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset_state();
    test_per_lane();
    test_reduction();
    test_saturation();
    test_single_beat();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
